multi_edge_detector: RTL and testbench
======================================

// Module: multi_edge_detector
// PURPOSE
//  N-channel, parametrised edge detector; successor of the single falling-edge detector.
//  Per channel: input synchroniser, glitch filter, runtime-selectable edge mode
//  (off/rise/fall/both), one-cycle event pulse, sticky pending flag, overrun flag.
//  Feeds the CPU's event/interrupt logic. Also usable for on-chip strobes that need
//  edge qualification.
// PARAMETERS
//  NUM_CH        4   number of independent channels (>=1)
//  SYNC_STAGES   2   synchroniser flops per channel (>=1; 1 = already-synchronous input)
//  FILTER_CYCLES 1   consecutive equal synchronised samples before a level is accepted (>=1)
//  RESET_LEVEL   1   assumed input level after reset (0/1), same for all channels
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-low (0 = reset)
//  din        in   NUM_CH    raw inputs, may be asynchronous
//  mode       in   2*NUM_CH  per-channel mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  clr        in   NUM_CH    write-1-to-clear for pending[i] and overrun[i]
//  irq_mask   in   NUM_CH    1 = channel may raise irq
//  edge_pulse out  NUM_CH    one-cycle pulse per qualified edge
//  level      out  NUM_CH    filtered, synchronised input level
//  pending    out  NUM_CH    sticky: qualified edge seen since last clear
//  overrun    out  NUM_CH    sticky: qualified edge seen while pending already set
//  irq        out  1         |(pending & irq_mask), combinational from registers
// BEHAVIOUR
//  - Reset (rst==0 at a rising clk): all sync flops and level = RESET_LEVEL; filter counters = 0;
//    edge_pulse, pending, overrun = 0. No pulse is generated on leaving reset if din == RESET_LEVEL.
//  - Sync: s[i] = output of SYNC_STAGES-deep shift register clocked from din[i].
//  - Filter, per channel, counter cnt of width clog2(FILTER_CYCLES)+1:
//    s == level -> cnt <= 0; s != level and cnt == FILTER_CYCLES-1 -> level <= s, cnt <= 0;
//    otherwise cnt <= cnt+1. A pulse shorter than FILTER_CYCLES synchronised samples is dropped.
//  - Qualified edge (q): level updates this cycle AND mode allows it
//    (0->1 needs mode[0], 1->0 needs mode[1]). edge_pulse[i] is registered, equal to q, and high
//    for exactly one cycle. Back-to-back edges are possible only for FILTER_CYCLES == 1.
//  - Latency: a din change first sampled at rising edge k gives edge_pulse high after edge
//    k+SYNC_STAGES+FILTER_CYCLES-1, i.e. during the following cycle.
//  - Mode 00: level is still tracked, no pulses, flags are not set. A mode change applies to the
//    next level update only and never produces a retroactive pulse.
//  - pending: set on q; cleared by clr[i]. Same cycle q and clr[i] -> pending = 1
//    (set wins, event not lost) and overrun = 0.
//  - overrun: set when q and pending==1 and !clr[i]; cleared by clr[i]; set wins only as above.
//  - Channels are fully independent. Simultaneous edges on several channels are all reported
//    in the same cycle.
//  - Reset mid-filter aborts the count. Any partially counted transition is discarded.
// STRUCTURE
//  - Package edge_det_pkg: localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10,
//    MODE_BOTH=2'b11.
//  - Sub-module edge_det_channel: sync chain, filter, edge qualification, and pending/overrun for
//    one channel.
//  - Top: generate loop over NUM_CH plus the irq reduction.
// TESTING
//  1 Reset: rst=0 for 3 clks with din=4'hF -> all outputs 0, level=4'hF. Release -> no
//    edge_pulse for 10 clks.
//  2 Latency: SYNC=2, FILTER=1, mode=both. din[0] 1->0 sampled at edge k -> edge_pulse[0] high
//    after edge k+2 for 1 cycle only, pending[0]=1.
//  3 Glitch: FILTER_CYCLES=4. din[1] low for 3 clks -> no pulse, level unchanged.
//    Low for 4 clks -> one pulse.
//  4 Modes: ch2 mode=01, 0->1->0 -> one pulse (rise only). mode=00 -> no pulse but level
//    follows.
//  5 Overrun/clear: two qualified edges on ch3 without clr -> overrun[3]=1. clr[3] coincident
//    with a third edge -> pending[3]=1, overrun[3]=0.
//  6 irq: pending=4'b0101, irq_mask=4'b0010 -> irq=0. irq_mask=4'b0100 -> irq=1 in the same
//    cycle.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared constants for the multi-channel edge detector: per-channel edge-mode encodings.
package edge_det_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_det_channel.sv
// One edge-detector channel: input synchroniser, glitch filter, edge qualification,
// and the sticky pending/overrun flags.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter bit RESET_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       edge_pulse,
    output logic       level,
    output logic       pending,
    output logic       overrun
);

    localparam int CW = $clog2(FILTER_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   upd;
    logic                   rise_en;
    logic                   fall_en;
    logic                   q;

    assign s = sync_q[SYNC_STAGES-1];

    // A level update and its qualification are decided in the same cycle, so a mode change
    // only ever affects the next accepted transition.
    always_comb begin
        upd     = (s != level) && (cnt == CNT_LAST);
        rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
        fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);
        q       = upd && (s ? rise_en : fall_en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q     <= {SYNC_STAGES{RESET_LEVEL}};
            level      <= RESET_LEVEL;
            cnt        <= '0;
            edge_pulse <= 1'b0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end

            if (s == level) begin
                cnt <= '0;
            end else if (upd) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            edge_pulse <= q;

            // A new event always wins over a clear so it is never lost.
            if (q) begin
                pending <= 1'b1;
                if (clr) begin
                    overrun <= 1'b0;
                end else if (pending) begin
                    overrun <= 1'b1;
                end
            end else if (clr) begin
                pending <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector feeding the CPU event/interrupt logic; one independent
// channel per input plus a masked interrupt reduction.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 1,
    parameter bit RESET_LEVEL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     din,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     clr,
    input  logic [NUM_CH-1:0]     irq_mask,
    output logic [NUM_CH-1:0]     edge_pulse,
    output logic [NUM_CH-1:0]     level,
    output logic [NUM_CH-1:0]     pending,
    output logic [NUM_CH-1:0]     overrun,
    output logic                  irq
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .din       (din[g]),
            .mode      (mode[2*g+1:2*g]),
            .clr       (clr[g]),
            .edge_pulse(edge_pulse[g]),
            .level     (level[g]),
            .pending   (pending[g]),
            .overrun   (overrun[g])
        );
    end

    assign irq = |(pending & irq_mask);

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: a FILTER_CYCLES=1 and a FILTER_CYCLES=4 instance
// share the stimulus; expected pulses are queued with their due cycle when din is driven.
module tb_multi_edge_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] irq_mask;

    logic [3:0] edge_pulse1, level1, pending1, overrun1;
    logic       irq1;
    logic [3:0] edge_pulse4, level4, pending4, overrun4;
    logic       irq4;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    exp_t sb1[$];
    exp_t sb4[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    multi_edge_detector #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .RESET_LEVEL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr), .irq_mask(irq_mask),
        .edge_pulse(edge_pulse1), .level(level1), .pending(pending1), .overrun(overrun1),
        .irq(irq1)
    );

    multi_edge_detector #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_LEVEL(1'b1)
    ) dut_f4 (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr), .irq_mask(irq_mask),
        .edge_pulse(edge_pulse4), .level(level4), .pending(pending4), .overrun(overrun4),
        .irq(irq4)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pops the expected pulse vector due in cycle c (zero when nothing is due).
    function automatic logic [3:0] pop_exp(input bit use4, input int c);
        exp_t e;
        pop_exp = 4'b0000;
        if (use4) begin
            if (sb4.size() > 0 && sb4[0].cyc == c) begin
                e = sb4.pop_front();
                pop_exp = e.v;
            end
        end else begin
            if (sb1.size() > 0 && sb1[0].cyc == c) begin
                e = sb1.pop_front();
                pop_exp = e.v;
            end
        end
    endfunction

    task automatic clear_all();
        clr = 4'hF;
        tick();
        clr = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0; din = 4'hF; mode = 8'hFF; clr = 4'h0; irq_mask = 4'h0;
        repeat (3) tick();
        checks++; if (edge_pulse1 !== 4'h0) begin failures++; $display("FAIL reset_pulse got=%h exp=0", edge_pulse1); end
        checks++; if (pending1 !== 4'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending1); end
        checks++; if (overrun1 !== 4'h0) begin failures++; $display("FAIL reset_overrun got=%h exp=0", overrun1); end
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq1); end
        checks++; if (level1 !== 4'hF) begin failures++; $display("FAIL reset_level got=%h exp=f", level1); end
        checks++; if (level4 !== 4'hF) begin failures++; $display("FAIL reset_level_f4 got=%h exp=f", level4); end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (edge_pulse1 !== 4'h0 || edge_pulse4 !== 4'h0) begin
                failures++;
                $display("FAIL post_reset_pulse cyc=%0d got=%h/%h exp=0/0", cyc, edge_pulse1, edge_pulse4);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp_v;
        mode = 8'hFF;
        clear_all();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin din[0] = 1'b0; sb1.push_back('{cyc + 3, 4'b0001}); end
            if (i == 5) begin din[0] = 1'b1; sb1.push_back('{cyc + 3, 4'b0001}); end
            tick();
            exp_v = pop_exp(1'b0, cyc);
            checks++;
            if (edge_pulse1 !== exp_v) begin
                failures++;
                $display("FAIL latency_pulse cyc=%0d got=%h exp=%h", cyc, edge_pulse1, exp_v);
            end
        end
        checks++; if (pending1[0] !== 1'b1) begin failures++; $display("FAIL latency_pending got=%b exp=1", pending1[0]); end
        checks++; if (overrun1[0] !== 1'b1) begin failures++; $display("FAIL latency_overrun got=%b exp=1", overrun1[0]); end
    endtask

    task automatic test_glitch();
        logic [3:0] exp_v;
        logic       exp_l;
        int         p;
        repeat (10) tick();
        clear_all();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) din[1] = 1'b0;
            if (i == 3) din[1] = 1'b1;
            tick();
            exp_v = pop_exp(1'b1, cyc);
            checks++;
            if (edge_pulse4 !== exp_v || level4[1] !== 1'b1) begin
                failures++;
                $display("FAIL glitch3 cyc=%0d pulse got=%h exp=%h level got=%b exp=1", cyc, edge_pulse4, exp_v, level4[1]);
            end
        end
        p = cyc;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin din[1] = 1'b0; sb4.push_back('{cyc + 6, 4'b0010}); end
            if (i == 4) begin din[1] = 1'b1; sb4.push_back('{cyc + 6, 4'b0010}); end
            tick();
            exp_v = pop_exp(1'b1, cyc);
            exp_l = (cyc >= p + 6 && cyc < p + 10) ? 1'b0 : 1'b1;
            checks++;
            if (edge_pulse4 !== exp_v || level4[1] !== exp_l) begin
                failures++;
                $display("FAIL glitch4 cyc=%0d pulse got=%h exp=%h level got=%b exp=%b", cyc, edge_pulse4, exp_v, level4[1], exp_l);
            end
        end
    endtask

    task automatic test_modes();
        logic [3:0] exp_v;
        mode = 8'hDF;
        clear_all();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) din[2] = 1'b0;
            if (i == 5) begin din[2] = 1'b1; sb1.push_back('{cyc + 3, 4'b0100}); end
            tick();
            exp_v = pop_exp(1'b0, cyc);
            checks++;
            if (edge_pulse1 !== exp_v) begin
                failures++;
                $display("FAIL mode_rise cyc=%0d got=%h exp=%h", cyc, edge_pulse1, exp_v);
            end
        end
        checks++; if (pending1[2] !== 1'b1) begin failures++; $display("FAIL mode_rise_pending got=%b exp=1", pending1[2]); end
        mode = 8'hCF;
        clear_all();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) din[2] = 1'b0;
            if (i == 6) begin
                checks++;
                if (level1[2] !== 1'b0) begin failures++; $display("FAIL mode_off_level got=%b exp=0", level1[2]); end
                din[2] = 1'b1;
            end
            tick();
            checks++;
            if (edge_pulse1 !== 4'h0) begin
                failures++;
                $display("FAIL mode_off_pulse cyc=%0d got=%h exp=0", cyc, edge_pulse1);
            end
        end
        checks++; if (level1[2] !== 1'b1) begin failures++; $display("FAIL mode_off_level_back got=%b exp=1", level1[2]); end
        checks++; if (pending1[2] !== 1'b0) begin failures++; $display("FAIL mode_off_pending got=%b exp=0", pending1[2]); end
        mode = 8'hFF;
    endtask

    task automatic test_overrun();
        logic [3:0] exp_v;
        clear_all();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin din[3] = 1'b0; sb1.push_back('{cyc + 3, 4'b1000}); end
            if (i == 4) begin din[3] = 1'b1; sb1.push_back('{cyc + 3, 4'b1000}); end
            tick();
            exp_v = pop_exp(1'b0, cyc);
            checks++;
            if (edge_pulse1 !== exp_v) begin
                failures++;
                $display("FAIL overrun_pulse cyc=%0d got=%h exp=%h", cyc, edge_pulse1, exp_v);
            end
        end
        checks++; if (overrun1[3] !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun1[3]); end
        checks++; if (pending1[3] !== 1'b1) begin failures++; $display("FAIL overrun_pending got=%b exp=1", pending1[3]); end
        // Third edge: clr[3] is held across exactly the edge that registers the event.
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin din[3] = 1'b0; sb1.push_back('{cyc + 3, 4'b1000}); end
            if (i == 2) clr[3] = 1'b1;
            if (i == 3) clr[3] = 1'b0;
            tick();
            exp_v = pop_exp(1'b0, cyc);
            checks++;
            if (edge_pulse1 !== exp_v) begin
                failures++;
                $display("FAIL clr_edge_pulse cyc=%0d got=%h exp=%h", cyc, edge_pulse1, exp_v);
            end
        end
        checks++; if (pending1[3] !== 1'b1) begin failures++; $display("FAIL clr_edge_pending got=%b exp=1", pending1[3]); end
        checks++; if (overrun1[3] !== 1'b0) begin failures++; $display("FAIL clr_edge_overrun got=%b exp=0", overrun1[3]); end
        din[3] = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_irq();
        logic [3:0] exp_v;
        clear_all();
        repeat (4) tick();
        clear_all();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin din = 4'b1010; sb1.push_back('{cyc + 3, 4'b0101}); end
            tick();
            exp_v = pop_exp(1'b0, cyc);
            checks++;
            if (edge_pulse1 !== exp_v) begin
                failures++;
                $display("FAIL simult_pulse cyc=%0d got=%h exp=%h", cyc, edge_pulse1, exp_v);
            end
        end
        checks++; if (pending1 !== 4'b0101) begin failures++; $display("FAIL irq_pending got=%b exp=0101", pending1); end
        irq_mask = 4'b0010;
        #1;
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", irq1); end
        irq_mask = 4'b0100;
        #1;
        checks++; if (irq1 !== 1'b1) begin failures++; $display("FAIL irq_unmasked got=%b exp=1", irq1); end
        clr = 4'b0100;
        tick();
        clr = 4'b0000;
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL irq_after_clr got=%b exp=0", irq1); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_modes();
        test_overrun();
        test_irq();
        checks++;
        if (sb1.size() != 0 || sb4.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", sb1.size(), sb4.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
